truth_table_checker: RTL and testbench
======================================

# truth_table_checker

Synthesizable response checker for the combinational-logic labs: the receiving end of the exhaustive stimulus sweep. It accepts one (vector index, DUT output) sample per handshake and compares z against a parameterised truth table. It accumulates mismatch count, first failing vector and vector coverage, then reports pass/fail once every input combination has been seen or the sample stream stalls.

## Interface
- N_IN, 3, number of DUT inputs; table depth is 2**N_IN
- TRUTH_TABLE, 'b00111001, expected output; bit i is z for input vector i ({x_2,x_1,x_0} = i)
- TIMEOUT, 64, max idle cycles in RUN between accepted samples before abort
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  begin/restart a check run (level sampled each cycle)
- vec_valid  in  1  sample present on vec_idx/z
- vec_idx  in  N_IN  input vector applied to DUT
- z  in  1  DUT output for vec_idx
- vec_ready  out  1  checker accepts sample this cycle
- busy  out  1  state is RUN
- done  out  1  state is DONE
- pass  out  1  valid when done: no mismatches and no timeout
- timeout  out  1  run ended by TIMEOUT
- error  out  1  one-cycle pulse, cycle after a mismatching accept
- err_count  out  N_IN+1  mismatches this run, saturating at all-ones
- first_err_valid  out  1  at least one mismatch recorded
- first_err_idx  out  N_IN  vec_idx of first mismatch
- coverage  out  2**N_IN  bit i set once vector i accepted

## Operation
- States: IDLE, RUN, DONE. Reset -> IDLE.
- IDLE: vec_ready=0. start=1 -> RUN, clearing err_count, first_err_*, coverage, timeout, timer.
- RUN: vec_ready=1. Accept = vec_valid & vec_ready.
  - On accept: expected = TRUTH_TABLE[vec_idx]. Mismatch (z != expected) -> error pulses the next cycle. err_count increments, saturating. If first_err_valid=0, latch first_err_idx=vec_idx and set first_err_valid.
  - coverage[vec_idx] set. Duplicate indices are checked and counted normally; coverage is unchanged.
  - If coverage including this accept is all ones -> DONE next cycle.
  - Idle timer counts cycles without accept and resets on each accept. When the timer reaches TIMEOUT -> DONE with timeout=1.
  - start=1 while in RUN restarts the run: counters clear and any sample accepted that cycle is discarded.
- DONE: vec_ready=0. Outputs hold. pass = (err_count==0) & ~timeout. start=1 -> RUN with a full clear.
- X/Z on z during accept counts as a mismatch (compare with !==).

## Timing
- Reset values: vec_ready=0, busy=0, done=0, pass=0, timeout=0, error=0, err_count=0, first_err_valid=0, first_err_idx=0, coverage=0.
- All outputs registered except vec_ready, which decodes directly from the state.
- Accept in cycle n updates err_count, coverage and first_err_* at edge n+1. error is high for exactly cycle n+1.
- Completion: the final covering accept at cycle n gives done=1 from cycle n+1. With back-to-back samples, 2**N_IN samples give done one cycle after the last one.
- Timeout: the TIMEOUT-th consecutive cycle in RUN without an accept raises done and timeout on the following edge.
- Asynchronous reset mid-run returns to IDLE immediately; partial results are lost.

## Structure
- Shared package checker_pkg holds the state encodings ST_IDLE/ST_RUN/ST_DONE (2-bit) and the default TRUTH_TABLE/N_IN constants reused by the stimulus generator.
- Sub-module gap_timer: counter with clear/enable, width $clog2(TIMEOUT+1), output expired. Top holds the FSM, compare logic and result registers.

## Test plan
- Correct DUT, vectors 0..7 back-to-back after start -> done=1 one cycle after vector 7; pass=1; err_count=0; coverage=8'hFF.
- z inverted at idx 5 only -> error pulse once; err_count=1; first_err_idx=5; pass=0 at done.
- All 8 outputs inverted, plus 2 duplicate wrong samples before the last index -> err_count saturates at 4'b1111... no: reaches 10 and is capped at 15; first_err_idx = first index sent.
- Send idx 0..6, then hold vec_valid=0 -> done and timeout after 64 idle cycles; pass=0; coverage=8'h7F.
- Duplicates 3,3,3, then the remaining indices -> coverage completes only when the last distinct index arrives; err_count=0; pass=1.
- Assert reset after 4 samples -> all outputs at reset values same cycle. start during RUN after 4 samples -> counters clear; a full sweep then reports pass=1.

Source files
------------

// File: rtl/checker_pkg.sv
// Shared definitions for the truth-table response checker and the stimulus
// generator that drives the device under test.
package checker_pkg;

  // Default lab configuration: a 3-input function swept exhaustively.
  localparam int unsigned DEF_N_IN  = 3;
  localparam int unsigned DEF_DEPTH = 2 ** DEF_N_IN;

  // Bit i is the expected z for input vector i ({x_2,x_1,x_0} = i).
  localparam logic [DEF_DEPTH-1:0] DEF_TRUTH_TABLE = 8'b0011_1001;

  // Idle cycles tolerated in RUN between accepted samples.
  localparam int unsigned DEF_TIMEOUT = 64;

  // Checker run states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : checker_pkg

// File: rtl/gap_timer.sv
// Idle-gap timer: counts consecutive enabled cycles since the last clear and
// flags the cycle that is the TIMEOUT-th one in a row.
module gap_timer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
  localparam logic [W-1:0] CAP  = W'(TIMEOUT);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear wins, otherwise advance while enabled, holding at TIMEOUT.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; a missing branch would otherwise infer a latch.
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != CAP)) begin
      count_d = count_q + W'(1);
    end
  end

  // count_q holds the number of idle cycles already completed, so the
  // current cycle is the TIMEOUT-th idle one when count_q == TIMEOUT-1.
  assign expired = enable & ~clear & (count_q == LAST);

  // Counter register.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule : gap_timer

// File: rtl/truth_table_checker.sv
// Response checker for exhaustive combinational-logic sweeps. Accepts one
// (vector index, z) sample per handshake, compares against TRUTH_TABLE and
// accumulates mismatch count, first failing index and vector coverage. A run
// ends when every vector has been seen or the sample stream stalls.
module truth_table_checker
  import checker_pkg::*;
#(
  parameter int unsigned             N_IN        = DEF_N_IN,
  parameter logic [2**N_IN-1:0]      TRUTH_TABLE = DEF_TRUTH_TABLE,
  parameter int unsigned             TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 vec_valid,
  input  logic [N_IN-1:0]      vec_idx,
  input  logic                 z,
  output logic                 vec_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic                 error,
  output logic [N_IN:0]        err_count,
  output logic                 first_err_valid,
  output logic [N_IN-1:0]      first_err_idx,
  output logic [2**N_IN-1:0]   coverage
);

  localparam int unsigned DEPTH = 2 ** N_IN;
  localparam int unsigned CW    = N_IN + 1;

  state_e state_q, state_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              timeout_q, timeout_d;
  logic              error_q, error_d;
  logic [CW-1:0]     err_count_q, err_count_d;
  logic              first_err_valid_q, first_err_valid_d;
  logic [N_IN-1:0]   first_err_idx_q, first_err_idx_d;
  logic [DEPTH-1:0]  coverage_q, coverage_d;

  logic              in_run;
  logic              accept;
  logic              expected_z;
  logic              mismatch;
  logic [DEPTH-1:0]  sample_onehot;
  logic [DEPTH-1:0]  cov_next;
  logic              all_covered;
  logic              timer_clear;
  logic              timer_expired;

  // ---------------------------------------------------------------------------
  // Sample qualification and comparison
  // ---------------------------------------------------------------------------
  assign in_run = (state_q == ST_RUN);

  // A sample arriving together with start is dropped: the run restarts.
  assign accept = vec_valid & vec_ready & ~start;

  assign expected_z = TRUTH_TABLE[vec_idx];

  // NOTE: case inequality so an X or Z on z is reported as a mismatch
  // instead of producing an unknown compare result in simulation.
  assign mismatch = (z !== expected_z);

  assign sample_onehot = {{(DEPTH-1){1'b0}}, 1'b1} << vec_idx;
  assign cov_next      = coverage_q | sample_onehot;
  assign all_covered   = &cov_next;

  // Gap timer only runs in RUN and restarts on every accepted or restarting cycle.
  assign timer_clear = ~in_run | start | accept;

  gap_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_gap_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (in_run),
    .expired (timer_expired)
  );

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start always (re)enters RUN; RUN ends on full coverage
  // or on an expired idle gap.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (start) begin
          state_d = ST_RUN;
        end else if (accept && all_covered) begin
          state_d = ST_DONE;
        end else if (timer_expired) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: vec_ready straight from the state, status flags from the
  // next state so they are registered alongside it.
  always_comb begin
    vec_ready = in_run;
    busy_d    = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
  end

  // ---------------------------------------------------------------------------
  // Result accumulation
  // ---------------------------------------------------------------------------

  // Next values of the result registers: clear on start, update on accept,
  // flag a timeout when the gap expires, freeze pass on entry to DONE.
  always_comb begin
    pass_d            = pass_q;
    timeout_d         = timeout_q;
    error_d           = 1'b0;
    err_count_d       = err_count_q;
    first_err_valid_d = first_err_valid_q;
    first_err_idx_d   = first_err_idx_q;
    coverage_d        = coverage_q;

    if (start) begin
      pass_d            = 1'b0;
      timeout_d         = 1'b0;
      err_count_d       = '0;
      first_err_valid_d = 1'b0;
      first_err_idx_d   = '0;
      coverage_d        = '0;
    end else if (accept) begin
      coverage_d = cov_next;
      if (mismatch) begin
        error_d = 1'b1;
        if (err_count_q != {CW{1'b1}}) begin
          err_count_d = err_count_q + CW'(1);
        end
        if (!first_err_valid_q) begin
          first_err_valid_d = 1'b1;
          first_err_idx_d   = vec_idx;
        end
      end
    end else if (in_run && timer_expired) begin
      timeout_d = 1'b1;
    end

    if (in_run && (state_d == ST_DONE)) begin
      pass_d = (err_count_d == '0) & ~timeout_d;
    end
  end

  // Result and status registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      pass_q            <= 1'b0;
      timeout_q         <= 1'b0;
      error_q           <= 1'b0;
      err_count_q       <= '0;
      first_err_valid_q <= 1'b0;
      first_err_idx_q   <= '0;
      coverage_q        <= '0;
    end else begin
      busy_q            <= busy_d;
      done_q            <= done_d;
      pass_q            <= pass_d;
      timeout_q         <= timeout_d;
      error_q           <= error_d;
      err_count_q       <= err_count_d;
      first_err_valid_q <= first_err_valid_d;
      first_err_idx_q   <= first_err_idx_d;
      coverage_q        <= coverage_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign timeout         = timeout_q;
  assign error           = error_q;
  assign err_count       = err_count_q;
  assign first_err_valid = first_err_valid_q;
  assign first_err_idx   = first_err_idx_q;
  assign coverage        = coverage_q;

endmodule : truth_table_checker

// File: tb/tb_truth_table_checker.sv
// Scoreboard bench for truth_table_checker: stimulus pushes the expected
// per-sample error flag and the expected end-of-run report; monitors pop and
// compare whenever the checker accepts a sample or raises done.
module tb_truth_table_checker;

  localparam logic [7:0] TT = 8'b0011_1001;

  typedef struct {
    logic       pass;
    logic       timeout;
    logic [3:0] err_count;
    logic       fev;
    logic [2:0] fei;
    logic [7:0] cov;
  } result_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       vec_valid;
  logic [2:0] vec_idx;
  logic       z;
  logic       vec_ready;
  logic       busy;
  logic       done;
  logic       pass;
  logic       timeout;
  logic       error;
  logic [3:0] err_count;
  logic       first_err_valid;
  logic [2:0] first_err_idx;
  logic [7:0] coverage;

  logic    err_q[$];
  result_t res_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic pend;
  logic pend_val;
  logic done_prev;

  truth_table_checker dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .vec_valid       (vec_valid),
    .vec_idx         (vec_idx),
    .z               (z),
    .vec_ready       (vec_ready),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .timeout         (timeout),
    .error           (error),
    .err_count       (err_count),
    .first_err_valid (first_err_valid),
    .first_err_idx   (first_err_idx),
    .coverage        (coverage)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Drive one sample for a full cycle; bad=1 inverts z against the table.
  task automatic send(input logic [2:0] idx, input logic bad);
    @(posedge clock); #1;
    vec_valid = 1'b1;
    vec_idx   = idx;
    z         = TT[idx] ^ bad;
    err_q.push_back(bad);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
      vec_valid = 1'b0;
    end
  endtask

  task automatic do_start();
    @(posedge clock); #1;
    vec_valid = 1'b0;
    start     = 1'b1;
    @(posedge clock); #1;
    start     = 1'b0;
  endtask

  task automatic expect_result(input logic p, input logic t, input logic [3:0] c,
                               input logic fv, input logic [2:0] fi, input logic [7:0] cv);
    result_t r;
    r.pass = p; r.timeout = t; r.err_count = c; r.fev = fv; r.fei = fi; r.cov = cv;
    res_q.push_back(r);
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (!done && cycles < budget) begin
      @(posedge clock); #1;
      cycles++;
    end
    check("done_reached", 32'(done), 32'd1);
  endtask

  // Error-pulse monitor: every accepted sample must be followed by exactly
  // the expected error level one cycle later; otherwise error stays low.
  always @(negedge clock) begin
    if (reset) begin
      pend = 1'b0;
    end else begin
      check("error_pulse", 32'(error), 32'(pend ? pend_val : 1'b0));
      pend = 1'b0;
      if (vec_valid && vec_ready && !start) begin
        if (err_q.size() == 0) begin
          fail_now("unexpected_accept");
        end else begin
          pend     = 1'b1;
          pend_val = err_q.pop_front();
        end
      end
    end
  end

  // Result monitor: compare the report on each rising done.
  always @(negedge clock) begin
    if (!reset && done && !done_prev) begin
      if (res_q.size() == 0) begin
        fail_now("unexpected_done");
      end else begin
        result_t r;
        r = res_q.pop_front();
        check("res_pass",      32'(pass),            32'(r.pass));
        check("res_timeout",   32'(timeout),         32'(r.timeout));
        check("res_err_count", 32'(err_count),       32'(r.err_count));
        check("res_fev",       32'(first_err_valid), 32'(r.fev));
        check("res_fei",       32'(first_err_idx),   32'(r.fei));
        check("res_coverage",  32'(coverage),        32'(r.cov));
        check("res_busy",      32'(busy),            32'd0);
      end
    end
    done_prev = done;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    done_prev = 1'b0;
    pend      = 1'b0;
    pend_val  = 1'b0;
    reset     = 1'b1;
    start     = 1'b0;
    vec_valid = 1'b0;
    vec_idx   = '0;
    z         = 1'b0;

    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    check("rst_vec_ready", 32'(vec_ready),       32'd0);
    check("rst_busy",      32'(busy),            32'd0);
    check("rst_done",      32'(done),            32'd0);
    check("rst_pass",      32'(pass),            32'd0);
    check("rst_timeout",   32'(timeout),         32'd0);
    check("rst_error",     32'(error),           32'd0);
    check("rst_err_count", 32'(err_count),       32'd0);
    check("rst_fev",       32'(first_err_valid), 32'd0);
    check("rst_fei",       32'(first_err_idx),   32'd0);
    check("rst_coverage",  32'(coverage),        32'd0);
    reset = 1'b0;
    idle(2);
    check("idle_not_ready", 32'(vec_ready), 32'd0);

    // Correct sweep 0..7 back-to-back: done one cycle after vector 7.
    expect_result(1'b1, 1'b0, 4'd0, 1'b0, 3'd0, 8'hFF);
    do_start();
    check("run_busy",  32'(busy),      32'd1);
    check("run_ready", 32'(vec_ready), 32'd1);
    for (int i = 0; i < 8; i++) send(3'(i), 1'b0);
    check("sweep_not_early", 32'(done), 32'd0);
    idle(1);
    check("sweep_done_latency", 32'(done),      32'd1);
    check("sweep_ready_low",    32'(vec_ready), 32'd0);
    idle(2);

    // z inverted at index 5 only.
    expect_result(1'b0, 1'b0, 4'd1, 1'b1, 3'd5, 8'hFF);
    do_start();
    for (int i = 0; i < 8; i++) send(3'(i), (i == 5));
    idle(1);
    check("inv5_done", 32'(done), 32'd1);
    idle(2);

    // Every output wrong plus two wrong duplicates: 10 errors, first index 3.
    expect_result(1'b0, 1'b0, 4'd10, 1'b1, 3'd3, 8'hFF);
    do_start();
    send(3'd3, 1'b1); send(3'd0, 1'b1); send(3'd1, 1'b1); send(3'd2, 1'b1);
    send(3'd4, 1'b1); send(3'd5, 1'b1); send(3'd6, 1'b1);
    send(3'd6, 1'b1); send(3'd6, 1'b1); send(3'd7, 1'b1);
    idle(1);
    check("allbad_done", 32'(done), 32'd1);
    idle(2);

    // 18 wrong samples: err_count saturates at 15.
    expect_result(1'b0, 1'b0, 4'd15, 1'b1, 3'd0, 8'hFF);
    do_start();
    for (int i = 0; i < 7; i++) send(3'(i), 1'b1);
    repeat (10) send(3'd0, 1'b1);
    send(3'd7, 1'b1);
    idle(1);
    check("sat_done", 32'(done), 32'd1);
    idle(2);

    // Duplicates 3,3,3 then the rest: completion only on the last distinct index.
    expect_result(1'b1, 1'b0, 4'd0, 1'b0, 3'd0, 8'hFF);
    do_start();
    send(3'd3, 1'b0); send(3'd3, 1'b0); send(3'd3, 1'b0);
    send(3'd0, 1'b0);
    check("dup_coverage", 32'(coverage), 32'h08);
    check("dup_not_done", 32'(done),     32'd0);
    send(3'd1, 1'b0); send(3'd2, 1'b0); send(3'd4, 1'b0);
    send(3'd5, 1'b0); send(3'd6, 1'b0);
    check("dup_not_done_6", 32'(done), 32'd0);
    send(3'd7, 1'b0);
    idle(1);
    check("dup_done", 32'(done), 32'd1);
    idle(2);

    // Send 0..6 then stall: done with timeout 64 cycles after the last accept.
    expect_result(1'b0, 1'b1, 4'd0, 1'b0, 3'd0, 8'h7F);
    do_start();
    for (int i = 0; i < 7; i++) send(3'(i), 1'b0);
    idle(1);
    wait_done(200, cyc);
    check("timeout_latency", 32'(cyc), 32'd64);
    idle(2);

    // start during RUN after 4 samples: clears results and drops that sample.
    expect_result(1'b1, 1'b0, 4'd0, 1'b0, 3'd0, 8'hFF);
    do_start();
    send(3'd0, 1'b0); send(3'd1, 1'b1); send(3'd2, 1'b0); send(3'd3, 1'b0);
    @(posedge clock); #1;
    check("pre_restart_err", 32'(err_count), 32'd1);
    start     = 1'b1;
    vec_valid = 1'b1;
    vec_idx   = 3'd4;
    z         = ~TT[4];
    @(posedge clock); #1;
    start     = 1'b0;
    vec_valid = 1'b0;
    check("restart_err_count", 32'(err_count),       32'd0);
    check("restart_coverage",  32'(coverage),        32'd0);
    check("restart_fev",       32'(first_err_valid), 32'd0);
    check("restart_busy",      32'(busy),            32'd1);
    for (int i = 0; i < 8; i++) send(3'(i), 1'b0);
    idle(1);
    check("restart_done", 32'(done), 32'd1);
    idle(2);

    // Asynchronous reset mid-run: everything back to reset values at once.
    do_start();
    send(3'd0, 1'b0); send(3'd1, 1'b0); send(3'd2, 1'b1); send(3'd3, 1'b0);
    idle(2);
    check("prereset_coverage", 32'(coverage), 32'h0F);
    reset = 1'b1;
    #1;
    check("arst_vec_ready", 32'(vec_ready),       32'd0);
    check("arst_busy",      32'(busy),            32'd0);
    check("arst_done",      32'(done),            32'd0);
    check("arst_pass",      32'(pass),            32'd0);
    check("arst_error",     32'(error),           32'd0);
    check("arst_err_count", 32'(err_count),       32'd0);
    check("arst_fev",       32'(first_err_valid), 32'd0);
    check("arst_coverage",  32'(coverage),        32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    idle(2);

    check("err_queue_drained", 32'(err_q.size()), 32'd0);
    check("res_queue_drained", 32'(res_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_truth_table_checker
